// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and response flag positions.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPT,
        RESP
    } state_e;

    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_ADDC     = 4'd1;
    localparam logic [3:0] OP_SUB      = 4'd2;
    localparam logic [3:0] OP_SUBB     = 4'd3;
    localparam logic [3:0] OP_AND      = 4'd4;
    localparam logic [3:0] OP_OR       = 4'd5;
    localparam logic [3:0] OP_XOR      = 4'd6;
    localparam logic [3:0] OP_NOT      = 4'd7;
    localparam logic [3:0] OP_SL       = 4'd8;
    localparam logic [3:0] OP_SR       = 4'd9;
    localparam logic [3:0] OP_LOAD_ACC = 4'd10;
    localparam logic [3:0] OP_READ_ACC = 4'd11;

    localparam int FLG_NEG  = 3;
    localparam int FLG_ZERO = 2;
    localparam int FLG_COUT = 1;
    localparam int FLG_OVF  = 0;

    function automatic logic is_alu_op(input logic [3:0] sel);
        return sel <= OP_SR;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command/response front end for the combinational ALU: registers the operands, waits one
// settle cycle, captures result and flags, and keeps a chaining accumulator.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         cmd_flagin,
    input  logic [3:0]   cmd_select,
    input  logic         cmd_use_acc,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_flagin,
    output logic [3:0]   alu_select,
    input  logic [N-1:0] alu_resultado,
    input  logic         alu_negativo,
    input  logic         alu_zero,
    input  logic         alu_cout,
    input  logic         alu_overflow,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_resultado,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [N-1:0] acc
);

    state_e         state_q, state_d;
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic           alu_flagin_q, alu_flagin_d;
    logic [3:0]     alu_select_q, alu_select_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_res_q, rsp_res_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;
    logic           rsp_err_q, rsp_err_d;
    logic [N-1:0]   acc_q, acc_d;

    // NOTE: every _d is given its hold value first, so no path leaves a signal unassigned
    // and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_flagin_d = alu_flagin_q;
        alu_select_d = alu_select_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_res_d    = rsp_res_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        acc_d        = acc_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d      = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d      = cmd_b;
                    alu_flagin_d = cmd_flagin;
                    alu_select_d = cmd_select;
                    state_d      = DRIVE;
                end
            end
            DRIVE: state_d = CAPT;
            CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_res_d   = '0;
                rsp_flags_d = '0;
                if (is_alu_op(alu_select_q)) begin
                    rsp_res_d   = alu_resultado;
                    rsp_flags_d = {alu_negativo, alu_zero, alu_cout, alu_overflow};
                    acc_d       = alu_resultado;
                end else if (alu_select_q == OP_LOAD_ACC) begin
                    rsp_res_d             = alu_a_q;
                    rsp_flags_d[FLG_ZERO] = (alu_a_q == '0);
                    acc_d                 = alu_a_q;
                end else if (alu_select_q == OP_READ_ACC) begin
                    rsp_res_d             = acc_q;
                    rsp_flags_d[FLG_ZERO] = (acc_q == '0);
                end else begin
                    rsp_err_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at
    // the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_flagin_q <= 1'b0;
            alu_select_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_res_q    <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_flagin_q <= alu_flagin_d;
            alu_select_q <= alu_select_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_res_q    <= rsp_res_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            acc_q        <= acc_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_flagin    = alu_flagin_q;
    assign alu_select    = alu_select_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_resultado = rsp_res_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_err       = rsp_err_q;
    assign acc           = acc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the alu_* lines, plus a transaction-level model
// of the accumulator and response contents used to predict every response.
module tb_alu_sequencer;

    localparam int N = 3;

    typedef struct packed {
        logic [N-1:0] res;
        logic [3:0]   flags;   // {neg, zero, cout, ovf}
    } alu_out_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_flagin;
    logic [3:0]   cmd_select;
    logic         cmd_use_acc;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_flagin;
    logic [3:0]   alu_select;
    logic [N-1:0] alu_resultado;
    logic         alu_negativo;
    logic         alu_zero;
    logic         alu_cout;
    logic         alu_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_resultado;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [N-1:0] acc;

    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0] m_acc;

    always #5 clk = ~clk;

    alu_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flagin(cmd_flagin),
        .cmd_select(cmd_select), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_flagin(alu_flagin), .alu_select(alu_select),
        .alu_resultado(alu_resultado), .alu_negativo(alu_negativo), .alu_zero(alu_zero),
        .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resultado(rsp_resultado), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .acc(acc)
    );

    // Behavioural ALU: 0 ADD, 1 ADD+carry, 2 SUB, 3 SUB+carry, 4 AND, 5 OR, 6 XOR, 7 NOT a,
    // 8 shift left (flagin in), 9 shift right (flagin in).
    function automatic alu_out_t alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic fl, input logic [3:0] sel);
        logic [N:0] s;
        logic [N:0] fl_x;
        logic       ovf;
        alu_out_t   r;
        fl_x = {{N{1'b0}}, fl};
        ovf  = 1'b0;
        case (sel)
            4'd0: s = {1'b0, a} + {1'b0, b};
            4'd1: s = {1'b0, a} + {1'b0, b} + fl_x;
            4'd2: s = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
            4'd3: s = {1'b0, a} + {1'b0, ~b} + fl_x;
            4'd4: s = {1'b0, a & b};
            4'd5: s = {1'b0, a | b};
            4'd6: s = {1'b0, a ^ b};
            4'd7: s = {1'b0, ~a};
            4'd8: s = {a, fl};
            4'd9: s = {a[0], fl, a[N-1:1]};
            default: s = '0;
        endcase
        if (sel <= 4'd1) ovf = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
        if (sel == 4'd2 || sel == 4'd3) ovf = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
        r.res   = s[N-1:0];
        r.flags = {s[N-1], (s[N-1:0] == '0), s[N], ovf};
        return r;
    endfunction

    alu_out_t alu_o;
    always_comb alu_o = alu_fn(alu_a, alu_b, alu_flagin, alu_select);
    assign alu_resultado = alu_o.res;
    assign {alu_negativo, alu_zero, alu_cout, alu_overflow} = alu_o.flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction, starting and ending at a negedge in IDLE.
    // hold < 0: rsp_ready held high throughout; otherwise rsp_ready held low for hold cycles.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic fl,
                         input logic [3:0] sel, input logic ua, input int hold);
        logic [N-1:0] a_eff, e_res, s_res;
        logic [3:0]   e_flags, s_flags;
        logic         e_err;
        alu_out_t     r;
        int           n;

        a_eff   = ua ? m_acc : a;
        e_res   = '0;
        e_flags = '0;
        e_err   = 1'b0;
        if (sel <= 4'd9) begin
            r       = alu_fn(a_eff, b, fl, sel);
            e_res   = r.res;
            e_flags = r.flags;
            m_acc   = r.res;
        end else if (sel == 4'd10) begin
            m_acc      = a_eff;
            e_res      = a_eff;
            e_flags[2] = (a_eff == '0);
        end else if (sel == 4'd11) begin
            e_res      = m_acc;
            e_flags[2] = (m_acc == '0);
        end else begin
            e_err = 1'b1;
        end

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_flagin  = fl;
        cmd_select  = sel;
        cmd_use_acc = ua;
        rsp_ready   = (hold < 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_a       = N'($urandom);
        cmd_b       = N'($urandom);
        cmd_select  = 4'($urandom);
        check("drive_cmd_ready", cmd_ready, 0);
        check("drive_alu_a", alu_a, a_eff);
        check("drive_alu_b", alu_b, b);
        check("drive_alu_flagin", alu_flagin, fl);
        check("drive_alu_select", alu_select, sel);

        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 3);
        check("rsp_resultado", rsp_resultado, e_res);
        check("rsp_flags", rsp_flags, e_flags);
        check("rsp_err", rsp_err, e_err);
        check("acc", acc, m_acc);

        if (hold < 0) begin
            @(negedge clk);
            check("resp_one_cycle", rsp_valid, 0);
            check("ready_after_resp", cmd_ready, 1);
            rsp_ready = 1'b0;
        end else begin
            s_res   = rsp_resultado;
            s_flags = rsp_flags;
            repeat (hold) begin
                cmd_valid = 1'b1;
                @(negedge clk);
                check("hold_valid", rsp_valid, 1);
                check("hold_res", rsp_resultado, s_res);
                check("hold_flags", rsp_flags, s_flags);
                check("hold_cmd_ready", cmd_ready, 0);
                check("hold_alu_a", alu_a, a_eff);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("handshake_valid", rsp_valid, 0);
            check("handshake_ready", cmd_ready, 1);
        end
    endtask

    task automatic reset_in_drive();
        check("rst_pre_ready", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_a       = 3'd4;
        cmd_b       = 3'd1;
        cmd_select  = 4'd0;
        cmd_use_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_in_drive", cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_acc = '0;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_a", alu_a, 0);
        repeat (4) begin
            @(negedge clk);
            check("no_stale_rsp", rsp_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_flagin  = 1'b0;
        cmd_select  = '0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b0;
        m_acc       = '0;
        repeat (2) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_res", rsp_resultado, 0);
        check("reset_rsp_flags", rsp_flags, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_acc", acc, 0);
        check("reset_alu_ab", {alu_a, alu_b}, 0);
        check("reset_alu_sel", {alu_flagin, alu_select}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3'd3, 3'd2, 1'b0, 4'd0, 1'b0, 0);    // 5, cout 0
        do_op(3'd6, 3'd3, 1'b0, 4'd0, 1'b0, 1);    // 1, cout 1
        do_op(3'd7, 3'd1, 1'b0, 4'd0, 1'b1, -1);   // acc + 1 = 2
        do_op(3'd0, 3'd5, 1'b0, 4'd10, 1'b0, 0);   // LOAD_ACC 0
        do_op(3'd5, 3'd5, 1'b0, 4'd11, 1'b0, 0);   // READ_ACC
        do_op(3'd2, 3'd3, 1'b0, 4'd13, 1'b0, 0);   // reserved
        do_op(3'd1, 3'd1, 1'b0, 4'd0, 1'b0, -1);   // normal after error
        do_op(3'd2, 3'd5, 1'b1, 4'd1, 1'b0, 5);    // stalled response
        reset_in_drive();
        do_op(3'd7, 3'd7, 1'b1, 4'd11, 1'b0, 0);   // acc cleared by reset

        for (int i = 0; i < 40; i++) begin
            do_op(N'($urandom), N'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), $urandom_range(0, 3) - 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
